// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues radix-2 DIT in-place FFT butterfly descriptors stage by stage.
// Optional bit-reverse load phase enabled by defining FFT_SEQ_BITREV_LOAD_EN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, n_pts, abort      control from CSR logic (n_pts = transform size N)
//   bf_valid/bf_ready        descriptor handshake: addr_a, addr_b, tw_k, tw_n, stage, last_in_stage
//   drain_done               writeback of issued butterflies complete (sampled in DRAIN)
//   busy, done, err          status; done/err are one-cycle pulses
//   load_valid/load_ready    bit-reverse load channel: load_addr, load_rev
module fft_stage_sequencer #(
    parameter int MAX_N       = 32,
    parameter int ADDR_WIDTH  = $clog2(MAX_N),
    parameter int STAGE_WIDTH = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    n_pts,
    input  logic                   abort,
    output logic                   bf_valid,
    input  logic                   bf_ready,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [ADDR_WIDTH-1:0]  tw_k,
    output logic [ADDR_WIDTH:0]    tw_n,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   last_in_stage,
    input  logic                   drain_done,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   load_valid,
    input  logic                   load_ready,
    output logic [ADDR_WIDTH-1:0]  load_addr,
    output logic [ADDR_WIDTH-1:0]  load_rev
);
`ifdef FFT_SEQ_BITREV_LOAD_EN
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE} state_t;
`endif
    localparam logic [ADDR_WIDTH:0] ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] NMAX = (ADDR_WIDTH + 1)'(MAX_N);
    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    n_q, n_d, tn_q, tn_d;
    logic [STAGE_WIDTH-1:0] l_q, l_d, s_q, s_d, lg;
    logic [ADDR_WIDTH-1:0]  j_q, j_d, a_q, a_d, b_q, b_d, k_q, k_d, half_d, pos_d;
    logic                   bf_valid_q, bf_valid_d, last_q, last_d, done_q, done_d;
    logic                   err_q, err_d, busy_q, ok, upd;
`ifdef FFT_SEQ_BITREV_LOAD_EN
    logic                   ld_valid_q, ld_valid_d;
    logic [ADDR_WIDTH-1:0]  ld_addr_q, ld_addr_d, ld_rev_q, ld_rev_d, rev;
`endif
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        l_d        = l_q;
        s_d        = s_q;
        j_d        = j_q;
        bf_valid_d = bf_valid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
        ld_valid_d = ld_valid_q;
        ld_addr_d  = ld_addr_q;
        rev        = '0;
`endif
        lg = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) if (n_pts[i]) lg = STAGE_WIDTH'(i);
        ok = (|n_pts[ADDR_WIDTH:1]) && (n_pts <= NMAX) && ((n_pts & (n_pts - ONE)) == '0);
        case (state_q)
            IDLE: if (start) begin
                if (ok) begin
                    n_d = n_pts;
                    l_d = lg;
                    s_d = '0;
                    j_d = '0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
                    state_d    = LOAD;
                    ld_valid_d = 1'b1;
                    ld_addr_d  = '0;
`else
                    state_d    = RUN;
                    bf_valid_d = 1'b1;
`endif
                end else err_d = 1'b1;
            end
`ifdef FFT_SEQ_BITREV_LOAD_EN
            LOAD: if (ld_valid_q && load_ready) begin
                if (ld_addr_q == ADDR_WIDTH'(n_q - ONE)) begin
                    state_d    = RUN;
                    ld_valid_d = 1'b0;
                    bf_valid_d = 1'b1;
                end else ld_addr_d = ld_addr_q + ADDR_WIDTH'(1);
            end
`endif
            RUN: if (bf_valid_q && bf_ready) begin
                if (last_q) begin
                    state_d    = DRAIN;
                    bf_valid_d = 1'b0;
                end else j_d = j_q + ADDR_WIDTH'(1);
            end
            DRAIN: if (drain_done) begin
                if (s_q == l_q - STAGE_WIDTH'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = RUN;
                    s_d        = s_q + STAGE_WIDTH'(1);
                    j_d        = '0;
                    bf_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            bf_valid_d = 1'b0;
            done_d     = 1'b0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
            ld_valid_d = 1'b0;
`endif
        end
        // Descriptor registers are loaded from the next (s, j) only while RUN is
        // the next state, so they hold during stalls and keep reset values until used.
        upd    = state_d == RUN;
        half_d = ADDR_WIDTH'(1) << s_d;
        pos_d  = j_d & (half_d - ADDR_WIDTH'(1));
        a_d    = upd ? (((j_d >> s_d) << (s_d + STAGE_WIDTH'(1))) | pos_d) : a_q;
        b_d    = upd ? (a_d | half_d) : b_q;
        k_d    = upd ? pos_d : k_q;
        tn_d   = upd ? ((ADDR_WIDTH + 1)'(2) << s_d) : tn_q;
        last_d = upd && (j_d == ADDR_WIDTH'((n_d >> 1) - ONE));
`ifdef FFT_SEQ_BITREV_LOAD_EN
        // Reverse over the full width, then shift down so only L bits remain.
        for (int b = 0; b < ADDR_WIDTH; b++) rev[b] = ld_addr_d[ADDR_WIDTH-1-b];
        ld_rev_d = rev >> (STAGE_WIDTH'(ADDR_WIDTH) - l_d);
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            l_q        <= '0;
            s_q        <= '0;
            j_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            tn_q       <= '0;
            bf_valid_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef FFT_SEQ_BITREV_LOAD_EN
            ld_valid_q <= 1'b0;
            ld_addr_q  <= '0;
            ld_rev_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            l_q        <= l_d;
            s_q        <= s_d;
            j_q        <= j_d;
            a_q        <= a_d;
            b_q        <= b_d;
            k_q        <= k_d;
            tn_q       <= tn_d;
            bf_valid_q <= bf_valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= state_d != IDLE;
`ifdef FFT_SEQ_BITREV_LOAD_EN
            ld_valid_q <= ld_valid_d;
            ld_addr_q  <= ld_addr_d;
            ld_rev_q   <= ld_rev_d;
`endif
        end
    end
    assign bf_valid      = bf_valid_q;
    assign addr_a        = a_q;
    assign addr_b        = b_q;
    assign tw_k          = k_q;
    assign tw_n          = tn_q;
    assign stage         = s_q;
    assign last_in_stage = last_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
`ifdef FFT_SEQ_BITREV_LOAD_EN
    assign load_valid = ld_valid_q;
    assign load_addr  = ld_addr_q;
    assign load_rev   = ld_rev_q;
`else
    logic unused_load_ready;
    assign unused_load_ready = load_ready;
    assign load_valid = 1'b0;
    assign load_addr  = '0;
    assign load_rev   = '0;
`endif
endmodule
